windowed_register_file: RTL and testbench
=========================================

# windowed_register_file

Parametrised SPARC windowed register file for the datapath: 8 globals plus NWINDOWS overlapping 16-register windows, two combinational read ports (A/B) and one clocked write port (C). It owns the Current Window Pointer (CWP) and executes SAVE/RESTORE with WIM-based overflow/underflow detection. It supports direct CWP load (WRPSR) and a multi-cycle hardware clear sequencer. It sits between the IR/MuxSa/MuxSc address selection and the ALU A/B muxes, and takes its write data from the ALU output.

## Interface
- WIDTH, 32, data width of every register
- NWINDOWS, 4, window count; legal range 2..32
- CWPW, $clog2(NWINDOWS) (min 1), CWP width (derived)
- Clk  in  1  clock; all state changes on posedge
- Clr_n  in  1  reset; synchronous, active-low
- RA, RB  in  5  read addresses for ports A and B
- RC  in  5  write address
- Din  in  WIDTH  write data
- We  in  1  write enable
- Save, Restore  in  1  window rotate requests, single-cycle
- Cwp_Ld  in  1  load CWP from Cwp_In
- Cwp_In  in  CWPW  new CWP value
- Wim  in  NWINDOWS  window invalid mask
- Clear  in  1  start full-array clear
- PortA, PortB  out  WIDTH  read data
- Cwp  out  CWPW  current window pointer
- Busy  out  1  clear sweep in progress
- Trap  out  1  one-cycle pulse on overflow/underflow
- TrapType  out  2  00 none, 01 overflow, 10 underflow, 11 illegal request

## Operation
- Physical array depth is 8+16·NWINDOWS. Globals r0–r7 map to phys 0–7.
- For r8–r31 in window w: phys = 8 + ((16·w + (r−8)) mod 16·NWINDOWS).
  - Outs r8–15 of window w alias ins r24–31 of window w−1.
- r0 always reads 0. Writes to r0 are discarded.
- Reads are combinational from current CWP. There is no write-to-read bypass: a same-cycle write is visible on the next cycle.
- Write: when We=1 and not Busy, Din is stored at phys(RC, Cwp) on the clock edge. The address uses the pre-update CWP even if Save/Restore/Cwp_Ld is active in the same cycle.
- Priority per cycle is Clr_n, then Busy, then Cwp_Ld, then Save/Restore.
- Cwp_Ld: if Cwp_In < NWINDOWS, Cwp ← Cwp_In. Otherwise Cwp is unchanged and Trap pulses with TrapType 11.
- Save: n = (Cwp−1) mod NWINDOWS.
  - Wim[n]=1: Cwp is unchanged; Trap pulses with type 01.
  - Otherwise Cwp ← n.
- Restore: n = (Cwp+1) mod NWINDOWS.
  - Wim[n]=1: Cwp is unchanged; Trap pulses with type 10.
  - Otherwise Cwp ← n.
- Save and Restore both asserted: no rotation; Trap pulses with type 11.
- Clear FSM states are IDLE and SWEEP.
  - IDLE→SWEEP on Clear=1. Index ← 0.
  - SWEEP writes 0 to phys[index] each cycle and increments index. It returns to IDLE after writing the last entry.
  - Busy=1 in SWEEP. We, Save, Restore, Cwp_Ld and Clear are ignored while Busy; no Trap is raised.

## Timing
- Reset (Clr_n=0 at an edge) sets Cwp=0, FSM=IDLE, Busy=0, Trap=0, TrapType=00.
  - Array contents are not reset.
  - Reset during SWEEP aborts the sweep; entries not yet reached keep their old values.
- Read latency: 0 cycles (combinational).
- Write latency: data is readable 1 cycle after the edge.
- CWP change is visible on PortA/PortB and Cwp 1 cycle after the request edge.
- Trap/TrapType are registered and asserted for exactly the cycle after the offending request. TrapType is 00 whenever Trap=0.
- Clear asserted at edge k: Busy=1 from k+1 through k+8+16·NWINDOWS, and Busy=0 thereafter.
- CWP wrap-around is modular in both directions: Save at 0 → NWINDOWS−1, Restore at NWINDOWS−1 → 0.

## Structure
- Shared package `sparc_rf_pkg`:
  - trap codes TT_NONE/TT_OVF/TT_UNF/TT_ILL
  - clear FSM state enum
  - constants NGLOBALS=8, WINREGS=16
- Sub-module `rf_phys_addr`: combinational (r, cwp) → physical index, parametrised by NWINDOWS. It is instanced three times, for RA, RB and RC.
- Top level holds the array, CWP register, rotate/trap logic and clear FSM.

## Test plan
- NWINDOWS=4, Wim=0: at Cwp=0 write r8=0xAAAA0001, then Save. Expect Cwp=3 and r24 reads 0xAAAA0001. Write r1=0x5, then Restore: r1 still reads 0x5.
- Wim=4'b1000, Cwp=0, Save → Cwp stays 0; Trap=1, TrapType=01 for 1 cycle. Wim=4'b0010, Cwp=0, Restore → TrapType=10.
- Cwp_Ld with Cwp_In=2 → Cwp=2. NWINDOWS=3, Cwp_Ld with Cwp_In=3 → Cwp unchanged, TrapType=11. Save+Restore together → TrapType=11, Cwp unchanged.
- Fill all 72 entries with nonzero values, pulse Clear. Expect Busy high for exactly 72 cycles, and a Save during Busy is ignored. Afterwards all 32 addresses in every window read 0.
- Pulse Clear; drive Clr_n=0 at cycle 10 of the sweep. Expect Busy=0 and Cwp=0 next cycle; phys entries 10..71 keep their prior values.
- We=1 with RC=0, Din=0xFFFFFFFF → r0 reads 0. Write r16 simultaneously with Save → data lands in the old window's local, not the new one.

Source files
------------

// File: rtl/sparc_rf_pkg.sv
// Shared definitions for the windowed register file: trap codes, clear FSM states
// and register-window geometry constants.
package sparc_rf_pkg;

    localparam int unsigned NGLOBALS = 8;
    localparam int unsigned WINREGS  = 16;

    typedef enum logic [1:0] {
        TT_NONE = 2'b00,
        TT_OVF  = 2'b01,
        TT_UNF  = 2'b10,
        TT_ILL  = 2'b11
    } trap_e;

    typedef enum logic {
        StIdle,
        StSweep
    } clr_state_e;

endpackage

// File: rtl/rf_phys_addr.sv
// Maps an architectural register number and window pointer onto the physical array index.
module rf_phys_addr
    import sparc_rf_pkg::*;
#(
    parameter int unsigned NWINDOWS = 4,
    parameter int unsigned CWPW     = ($clog2(NWINDOWS) < 1) ? 1 : $clog2(NWINDOWS),
    parameter int unsigned PW       = $clog2(NGLOBALS + WINREGS * NWINDOWS)
) (
    input  logic [4:0]      r,
    input  logic [CWPW-1:0] cwp,
    output logic [PW-1:0]   phys
);

    int unsigned off;

    always_comb begin
        // Window offsets never exceed two ring lengths, so one conditional subtract suffices.
        off = WINREGS * 32'(cwp) + 32'(r) - NGLOBALS;
        if (off >= WINREGS * NWINDOWS) begin
            off = off - WINREGS * NWINDOWS;
        end
        if (r < 5'(NGLOBALS)) begin
            phys = PW'(r);
        end else begin
            phys = PW'(NGLOBALS + off);
        end
    end

endmodule

// File: rtl/windowed_register_file.sv
// SPARC windowed register file: global + overlapping windows, CWP rotate/trap logic
// and a hardware clear sequencer that sweeps every physical entry to zero.
module windowed_register_file
    import sparc_rf_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NWINDOWS = 4,
    parameter int unsigned CWPW     = ($clog2(NWINDOWS) < 1) ? 1 : $clog2(NWINDOWS)
) (
    input  logic             Clk,
    input  logic             Clr_n,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    input  logic [4:0]       RC,
    input  logic [WIDTH-1:0] Din,
    input  logic             We,
    input  logic             Save,
    input  logic             Restore,
    input  logic             Cwp_Ld,
    input  logic [CWPW-1:0]  Cwp_In,
    input  logic [NWINDOWS-1:0] Wim,
    input  logic             Clear,
    output logic [WIDTH-1:0] PortA,
    output logic [WIDTH-1:0] PortB,
    output logic [CWPW-1:0]  Cwp,
    output logic             Busy,
    output logic             Trap,
    output logic [1:0]       TrapType
);

    localparam int unsigned DEPTH = NGLOBALS + WINREGS * NWINDOWS;
    localparam int unsigned PW    = $clog2(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];

    logic [CWPW-1:0] cwp_q, cwp_d;
    clr_state_e      state_q, state_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic            trap_q, trap_d;
    trap_e           tt_q, tt_d;
    logic [CWPW-1:0] save_n, restore_n;
    logic [PW-1:0]   phys_a, phys_b, phys_c;

    rf_phys_addr #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_addr_a (
        .r    (RA),
        .cwp  (cwp_q),
        .phys (phys_a)
    );

    rf_phys_addr #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_addr_b (
        .r    (RB),
        .cwp  (cwp_q),
        .phys (phys_b)
    );

    rf_phys_addr #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_addr_c (
        .r    (RC),
        .cwp  (cwp_q),
        .phys (phys_c)
    );

    assign PortA    = (RA == 5'd0) ? '0 : regs_q[phys_a];
    assign PortB    = (RB == 5'd0) ? '0 : regs_q[phys_b];
    assign Cwp      = cwp_q;
    assign Busy     = (state_q == StSweep);
    assign Trap     = trap_q;
    assign TrapType = tt_q;

    assign save_n    = (cwp_q == '0) ? CWPW'(NWINDOWS - 1) : cwp_q - CWPW'(1);
    assign restore_n = (cwp_q == CWPW'(NWINDOWS - 1)) ? '0 : cwp_q + CWPW'(1);

    always_comb begin
        cwp_d   = cwp_q;
        state_d = state_q;
        idx_d   = idx_q;
        trap_d  = 1'b0;
        tt_d    = TT_NONE;
        unique case (state_q)
            StIdle: begin
                if (Clear) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
                if (Cwp_Ld) begin
                    if (32'(Cwp_In) < NWINDOWS) begin
                        cwp_d = Cwp_In;
                    end else begin
                        trap_d = 1'b1;
                        tt_d   = TT_ILL;
                    end
                end else if (Save && Restore) begin
                    trap_d = 1'b1;
                    tt_d   = TT_ILL;
                end else if (Save) begin
                    if (Wim[save_n]) begin
                        trap_d = 1'b1;
                        tt_d   = TT_OVF;
                    end else begin
                        cwp_d = save_n;
                    end
                end else if (Restore) begin
                    if (Wim[restore_n]) begin
                        trap_d = 1'b1;
                        tt_d   = TT_UNF;
                    end else begin
                        cwp_d = restore_n;
                    end
                end
            end
            StSweep: begin
                idx_d = idx_q + PW'(1);
                if (idx_q == PW'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            cwp_q   <= '0;
            state_q <= StIdle;
            idx_q   <= '0;
            trap_q  <= 1'b0;
            tt_q    <= TT_NONE;
        end else begin
            cwp_q   <= cwp_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            trap_q  <= trap_d;
            tt_q    <= tt_d;
        end
    end

    // Array has no reset; a reset mid-sweep leaves unreached entries untouched.
    always_ff @(posedge Clk) begin
        if (Clr_n) begin
            if (state_q == StSweep) begin
                regs_q[idx_q] <= '0;
            end else if (We && (RC != 5'd0)) begin
                regs_q[phys_c] <= Din;
            end
        end
    end

endmodule

// File: tb/tb_windowed_register_file.sv
// Directed self-checking bench for windowed_register_file (NWINDOWS=4 main, NWINDOWS=3 side).
module tb_windowed_register_file;

    logic        Clk = 1'b0;
    logic        Clr_n = 1'b0;
    logic [4:0]  RA = '0, RB = '0, RC = '0;
    logic [31:0] Din = '0;
    logic        We = 1'b0, Save = 1'b0, Restore = 1'b0, Cwp_Ld = 1'b0, Clear = 1'b0;
    logic [1:0]  Cwp_In = '0;
    logic [3:0]  Wim = '0;

    logic [31:0] PortA, PortB, PortA3, PortB3;
    logic [1:0]  Cwp, Cwp3, TrapType, TrapType3;
    logic        Busy, Busy3, Trap, Trap3;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    windowed_register_file #(.WIDTH(32), .NWINDOWS(4)) u_dut (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .RA       (RA),
        .RB       (RB),
        .RC       (RC),
        .Din      (Din),
        .We       (We),
        .Save     (Save),
        .Restore  (Restore),
        .Cwp_Ld   (Cwp_Ld),
        .Cwp_In   (Cwp_In),
        .Wim      (Wim),
        .Clear    (Clear),
        .PortA    (PortA),
        .PortB    (PortB),
        .Cwp      (Cwp),
        .Busy     (Busy),
        .Trap     (Trap),
        .TrapType (TrapType)
    );

    windowed_register_file #(.WIDTH(32), .NWINDOWS(3)) u_dut3 (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .RA       (RA),
        .RB       (RB),
        .RC       (RC),
        .Din      (Din),
        .We       (We),
        .Save     (Save),
        .Restore  (Restore),
        .Cwp_Ld   (Cwp_Ld),
        .Cwp_In   (Cwp_In),
        .Wim      (Wim[2:0]),
        .Clear    (Clear),
        .PortA    (PortA3),
        .PortB    (PortB3),
        .Cwp      (Cwp3),
        .Busy     (Busy3),
        .Trap     (Trap3),
        .TrapType (TrapType3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int r, input logic [31:0] d);
        We = 1'b1; RC = 5'(r); Din = d;
        tick();
        We = 1'b0;
    endtask

    task automatic ld(input int w);
        Cwp_Ld = 1'b1; Cwp_In = 2'(w);
        tick();
        Cwp_Ld = 1'b0;
    endtask

    // Physical entry p gets 0x1000_0000|p; window w's r8..r23 span phys 16w+8..16w+23.
    task automatic fill();
        for (int r = 1; r < 8; r++) wr(r, 32'h1000_0000 | 32'(r));
        for (int w = 0; w < 4; w++) begin
            ld(w);
            for (int r = 8; r < 24; r++) wr(r, 32'h1000_0000 | 32'(16 * w + r));
        end
    endtask

    initial begin
        int cnt;
        int bad;
        logic trap_seen;
        logic [31:0] acc;

        tick();
        Clr_n = 1'b1;
        check("reset_cwp", 32'(Cwp), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_trap", 32'(Trap), 32'd0);
        check("reset_tt", 32'(TrapType), 32'd0);

        // Window overlap: outs of window 0 are ins of window 3
        wr(8, 32'hAAAA_0001);
        RA = 5'd8; #1;
        check("r8_w0", PortA, 32'hAAAA_0001);
        Save = 1'b1; tick(); Save = 1'b0;
        check("save_cwp", 32'(Cwp), 32'd3);
        RA = 5'd24; #1;
        check("r24_w3_alias", PortA, 32'hAAAA_0001);
        wr(1, 32'h5);
        Restore = 1'b1; tick(); Restore = 1'b0;
        check("restore_cwp", 32'(Cwp), 32'd0);
        RA = 5'd1; #1;
        check("global_r1", PortA, 32'h5);

        // Write coinciding with Save uses the pre-rotation window
        Save = 1'b1; tick(); Save = 1'b0;
        wr(16, 32'h3333_3333);
        Restore = 1'b1; tick(); Restore = 1'b0;
        We = 1'b1; RC = 5'd16; Din = 32'h00C0_FFEE; Save = 1'b1;
        tick();
        We = 1'b0; Save = 1'b0;
        check("save_wr_cwp", 32'(Cwp), 32'd3);
        RA = 5'd16; #1;
        check("save_wr_new_win", PortA, 32'h3333_3333);
        Restore = 1'b1; tick(); Restore = 1'b0;
        RA = 5'd16; #1;
        check("save_wr_old_win", PortA, 32'h00C0_FFEE);

        // r0 is hardwired to zero
        wr(0, 32'hFFFF_FFFF);
        RA = 5'd0; RB = 5'd0; #1;
        check("r0_porta", PortA, 32'd0);
        check("r0_portb", PortB, 32'd0);

        // Overflow / underflow traps
        Wim = 4'b1000;
        Save = 1'b1; tick(); Save = 1'b0;
        check("ovf_trap", 32'(Trap), 32'd1);
        check("ovf_tt", 32'(TrapType), 32'd1);
        check("ovf_cwp", 32'(Cwp), 32'd0);
        tick();
        check("ovf_trap_end", 32'(Trap), 32'd0);
        check("ovf_tt_end", 32'(TrapType), 32'd0);
        Wim = 4'b0010;
        Restore = 1'b1; tick(); Restore = 1'b0;
        check("unf_trap", 32'(Trap), 32'd1);
        check("unf_tt", 32'(TrapType), 32'd2);
        check("unf_cwp", 32'(Cwp), 32'd0);
        Wim = 4'b0000;

        // Direct load, illegal load on the 3-window instance, Save+Restore conflict
        ld(2);
        check("ld_cwp", 32'(Cwp), 32'd2);
        check("ld_cwp3", 32'(Cwp3), 32'd2);
        check("ld_notrap", 32'(Trap), 32'd0);
        ld(3);
        check("ill_ld_cwp3", 32'(Cwp3), 32'd2);
        check("ill_ld_trap3", 32'(Trap3), 32'd1);
        check("ill_ld_tt3", 32'(TrapType3), 32'd3);
        check("ld3_cwp", 32'(Cwp), 32'd3);
        Save = 1'b1; Restore = 1'b1; tick(); Save = 1'b0; Restore = 1'b0;
        check("both_tt", 32'(TrapType), 32'd3);
        check("both_cwp", 32'(Cwp), 32'd3);

        // Full clear; Save held throughout must be ignored
        fill();
        RA = 5'd23; #1;
        check("fill_sample", PortA, 32'h1000_0000 | 32'd71);
        Clear = 1'b1; tick(); Clear = 1'b0;
        Save = 1'b1;
        cnt = 0;
        trap_seen = 1'b0;
        while (Busy && cnt < 200) begin
            cnt++;
            trap_seen = trap_seen | Trap;
            tick();
        end
        check("clear_busy_cycles", 32'(cnt), 32'd72);
        check("clear_save_ignored", 32'(Cwp), 32'd3);
        check("clear_no_trap", 32'(trap_seen), 32'd0);
        Save = 1'b0;
        for (int w = 0; w < 4; w++) begin
            ld(w);
            acc = '0;
            for (int r = 0; r < 32; r++) begin
                RA = 5'(r); RB = 5'(31 - r); #1;
                acc = acc | PortA | PortB;
            end
            check($sformatf("clear_win%0d", w), acc, 32'd0);
        end

        // Reset during sweep index 10: entries 0..9 zeroed, 10..71 preserved
        fill();
        Clear = 1'b1; tick(); Clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        Clr_n = 1'b0; tick(); Clr_n = 1'b1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_cwp", 32'(Cwp), 32'd0);
        bad = 0;
        for (int r = 1; r < 8; r++) begin
            RA = 5'(r); #1;
            if (PortA !== 32'd0) bad++;
        end
        for (int w = 0; w < 4; w++) begin
            ld(w);
            for (int r = 8; r < 24; r++) begin
                RA = 5'(r); #1;
                if ((16 * w + r) < 10) begin
                    if (PortA !== 32'd0) bad++;
                end else if (PortA !== (32'h1000_0000 | 32'(16 * w + r))) begin
                    bad++;
                end
            end
        end
        check("abort_entries_bad", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
